fetch_ifid: RTL and testbench
=============================

Name: fetch_ifid

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit five-stage core. Holds the PC and issues reads to a variable-latency instruction memory. Delivers the fetched instruction and PC+2 to decode. Consumes `stall` and `branchStall` from the hazard detector and a PC redirect from the branch/jump resolution stage; inserts NOP bubbles when required.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding injected into IF/ID as a bubble (opcode 00001)
HALT_OP, 5'b00000, opcode (instr[15:11]) recognised as HALT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard detector: freeze PC and IF/ID
branchStall  input  1  hazard detector: control transfer in flight; hold PC, bubble IF/ID
redirect  input  1  resolved taken branch/jump; squash fetch path
redirectPC  input  16  target PC, valid with redirect
imemReq  output  1  read request, held until imemDone
imemAddr  output  16  read address, stable while imemReq=1
imemData  input  16  read data, valid only when imemDone=1
imemDone  input  1  read complete; may rise in the same cycle imemReq rises
instr_IFID  output  16  instruction to decode
pcPlus2_IFID  output  16  PC of that instruction + 2
valid_IFID  output  1  1 = real instruction, 0 = bubble
pc  output  16  current fetch PC
halted  output  1  fetch stopped on HALT

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, instr_IFID=NOP_INSTR, pcPlus2_IFID=0, valid_IFID=0, halted=0, squash=0, state=FETCH. imemReq=0 during any cycle with rst=1.
- States: FETCH, WAIT_MEM, HALTED.
- FETCH: imemReq=1 and imemAddr=pc combinationally; reqAddr<=pc.
  - Not imemDone: go to WAIT_MEM.
  - imemDone: take the accept decision below, then stay in FETCH.
- WAIT_MEM: imemReq=1, imemAddr=reqAddr. pc may change here; imemAddr must not.
  - imemDone: apply the accept decision (forced discard if squash=1), clear squash, return to FETCH.
- Accept decision, priority highest first:
  - redirect: pc<=redirectPC; IF/ID<=NOP/valid 0; data discarded. In WAIT_MEM without imemDone, set squash=1.
  - branchStall: pc held; IF/ID<=NOP/valid 0; data discarded.
  - stall: pc held; IF/ID held; data discarded and re-fetched.
  - Otherwise with imemDone and no squash: instr_IFID<=imemData, pcPlus2_IFID<=reqAddr+2 (mod 2^16), valid_IFID<=1, pc<=reqAddr+2.
- Cycles with no accepted data and no stall: IF/ID<=NOP/valid 0. With stall=1 and no redirect/branchStall, IF/ID holds even without data.
- HALT: accepted instruction with instr[15:11]==HALT_OP is latched into IF/ID normally. Then pc is held at the HALT address (not +2), state goes to HALTED, halted=1.
- HALTED: imemReq=0; IF/ID<=NOP/valid 0 unless stall holds it. redirect clears halted, loads pc<=redirectPC, goes to FETCH (wrong-path HALT). Only redirect or rst leaves HALTED.
- redirect coincident with imemDone in WAIT_MEM: data discarded, squash stays 0, next FETCH uses redirectPC.
- PC wraps 16'hFFFE -> 16'h0000. Bit 0 of redirectPC is passed through unchanged; alignment is not checked here.
- At most one outstanding memory read; imemReq never deasserts before imemDone except under rst.
- rst mid-read: state is reset. A later imemDone with no request pending is ignored.

Test Plan:
- Reset, then imemDone same-cycle with imemData=16'h4000 -> next cycle: instr_IFID=16'h4000, pcPlus2_IFID=16'h0002, valid_IFID=1, pc=16'h0002, imemAddr=16'h0002.
- stall=1 for 3 cycles at pc=16'h0004 with instant imemDone -> pc, instr_IFID and pcPlus2_IFID unchanged all 3 cycles; after release, 16'h0004's data is latched.
- branchStall=1 for 2 cycles -> instr_IFID=16'h0800, valid_IFID=0, pc held; normal fetch resumes the cycle after deassertion.
- Memory latency 3 cycles; redirect to 16'h0040 in cycle 1 of WAIT_MEM -> imemAddr stays at old address until imemDone; returned data discarded; next request imemAddr=16'h0040.
- Fetch 16'h0000 (HALT) at pc=16'h000A -> halted=1, pc=16'h000A, imemReq=0 for 5 idle cycles; then redirect to 16'h0010 -> halted=0, imemAddr=16'h0010.
- redirect, branchStall and stall all high in one cycle with imemDone -> pc=redirectPC, valid_IFID=0; repeat with pc=16'hFFFE, no stalls -> pcPlus2_IFID=16'h0000.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
interface fetch_ifid_if;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemDone;

    modport master (output imemReq, output imemAddr, input imemData, input imemDone);
    modport slave  (input imemReq, input imemAddr, output imemData, output imemDone);
endinterface

// File: rtl/fetch_ifid.sv
// Instruction fetch stage with IF/ID pipeline register for the 16-bit five-stage core.
// One outstanding read to a variable-latency memory; stalls, bubbles, redirects and HALT.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branchStall,
    input  logic          redirect,
    input  logic [15:0]   redirectPC,
    fetch_ifid_if.master  imem,
    output logic [15:0]   instr_IFID,
    output logic [15:0]   pcPlus2_IFID,
    output logic          valid_IFID,
    output logic [15:0]   pc,
    output logic          halted
);
    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] HALTED   = 2'd2;

    logic [1:0]  state, state_d;
    logic [15:0] req_addr, req_addr_d;
    logic        squash, squash_d;
    logic [15:0] pc_d, instr_d, pcplus2_d;
    logic        valid_d, halted_d;
    logic [15:0] cur_addr;
    logic        discard;
    logic        halt_hit;

    // Once a read is in flight the address is frozen in req_addr, so pc may move freely.
    assign cur_addr      = (state == WAIT_MEM) ? req_addr : pc;
    assign discard       = (state == WAIT_MEM) && squash;
    assign halt_hit      = (imem.imemData[15:11] == HALT_OP);
    assign imem.imemReq  = !rst && ((state == FETCH) || (state == WAIT_MEM));
    assign imem.imemAddr = cur_addr;

    always_comb begin
        state_d    = state;
        req_addr_d = req_addr;
        squash_d   = squash;
        pc_d       = pc;
        instr_d    = instr_IFID;
        pcplus2_d  = pcPlus2_IFID;
        valid_d    = valid_IFID;
        halted_d   = halted;
        case (state)
            FETCH, WAIT_MEM: begin
                req_addr_d = cur_addr;
                state_d    = imem.imemDone ? FETCH : WAIT_MEM;
                // A redirect while the read is still pending poisons its eventual data.
                squash_d   = !imem.imemDone && (squash || redirect);
                if (redirect) begin
                    pc_d    = redirectPC;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (branchStall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (stall) begin
                    instr_d = instr_IFID;
                end else if (imem.imemDone && !discard) begin
                    instr_d   = imem.imemData;
                    pcplus2_d = cur_addr + 16'd2;
                    valid_d   = 1'b1;
                    if (halt_hit) begin
                        pc_d     = cur_addr;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_d = cur_addr + 16'd2;
                    end
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HALTED: begin
                if (redirect) begin
                    pc_d     = redirectPC;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                    instr_d  = NOP_INSTR;
                    valid_d  = 1'b0;
                end else if (branchStall || !stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            req_addr     <= RESET_PC;
            squash       <= 1'b0;
            pc           <= RESET_PC;
            instr_IFID   <= NOP_INSTR;
            pcPlus2_IFID <= 16'h0000;
            valid_IFID   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_d;
            req_addr     <= req_addr_d;
            squash       <= squash_d;
            pc           <= pc_d;
            instr_IFID   <= instr_d;
            pcPlus2_IFID <= pcplus2_d;
            valid_IFID   <= valid_d;
            halted       <= halted_d;
        end
    end
endmodule

// File: tb/tb_fetch_ifid.sv
// Directed scenarios plus randomized traffic against a transaction-level fetch model.
module tb_fetch_ifid;
    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, branchStall = 1'b0, redirect = 1'b0, done = 1'b0;
    logic [15:0] redirectPC = 16'h0000;
    logic [15:0] instr_IFID, pcPlus2_IFID, pc;
    logic        valid_IFID, halted;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [65536];

    fetch_ifid_if bus ();
    assign bus.imemData = mem[bus.imemAddr];
    assign bus.imemDone = done;

    fetch_ifid dut (
        .clk(clk), .rst(rst), .stall(stall), .branchStall(branchStall),
        .redirect(redirect), .redirectPC(redirectPC), .imem(bus),
        .instr_IFID(instr_IFID), .pcPlus2_IFID(pcPlus2_IFID), .valid_IFID(valid_IFID),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; done = 1'b0; stall = 1'b0; branchStall = 1'b0; redirect = 1'b0;
        tick(); tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (instr_IFID !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr_IFID, NOP); end
        checks++; if (pcPlus2_IFID !== 16'h0000) begin errors++; $display("FAIL reset_pp2 got=%h exp=0000", pcPlus2_IFID); end
        checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_IFID); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imemReq); end
    endtask

    task automatic test_first_fetch;
        mem[16'h0000] = 16'h4000;
        mem[16'h0002] = 16'h1111;
        done = 1'b1; rst = 1'b0;
        #1;
        checks++; if (bus.imemReq !== 1'b1) begin errors++; $display("FAIL ff_req got=%b exp=1", bus.imemReq); end
        checks++; if (bus.imemAddr !== 16'h0000) begin errors++; $display("FAIL ff_addr0 got=%h exp=0000", bus.imemAddr); end
        tick();
        checks++; if (instr_IFID !== 16'h4000) begin errors++; $display("FAIL ff_instr got=%h exp=4000", instr_IFID); end
        checks++; if (pcPlus2_IFID !== 16'h0002) begin errors++; $display("FAIL ff_pp2 got=%h exp=0002", pcPlus2_IFID); end
        checks++; if (valid_IFID !== 1'b1) begin errors++; $display("FAIL ff_valid got=%b exp=1", valid_IFID); end
        checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL ff_pc got=%h exp=0002", pc); end
        checks++; if (bus.imemAddr !== 16'h0002) begin errors++; $display("FAIL ff_addr got=%h exp=0002", bus.imemAddr); end
        tick();
        checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL ff_pc2 got=%h exp=0004", pc); end
    endtask

    task automatic test_stall;
        mem[16'h0004] = 16'h2345;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=0004", i, pc); end
            checks++; if (instr_IFID !== 16'h1111) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=1111", i, instr_IFID); end
            checks++; if (pcPlus2_IFID !== 16'h0004) begin errors++; $display("FAIL stall_pp2[%0d] got=%h exp=0004", i, pcPlus2_IFID); end
        end
        stall = 1'b0;
        tick();
        checks++; if (instr_IFID !== 16'h2345) begin errors++; $display("FAIL stall_rel_instr got=%h exp=2345", instr_IFID); end
        checks++; if (pcPlus2_IFID !== 16'h0006) begin errors++; $display("FAIL stall_rel_pp2 got=%h exp=0006", pcPlus2_IFID); end
        checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL stall_rel_pc got=%h exp=0006", pc); end
    endtask

    task automatic test_branch_stall;
        mem[16'h0006] = 16'h3456;
        branchStall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_IFID !== NOP) begin errors++; $display("FAIL bs_instr[%0d] got=%h exp=%h", i, instr_IFID, NOP); end
            checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL bs_valid[%0d] got=%b exp=0", i, valid_IFID); end
            checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL bs_pc[%0d] got=%h exp=0006", i, pc); end
        end
        branchStall = 1'b0;
        tick();
        checks++; if (instr_IFID !== 16'h3456) begin errors++; $display("FAIL bs_rel_instr got=%h exp=3456", instr_IFID); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL bs_rel_pc got=%h exp=0008", pc); end
    endtask

    task automatic test_redirect_wait;
        mem[16'h0008] = 16'h5555;
        mem[16'h0040] = 16'h6666;
        done = 1'b0;
        tick();
        checks++; if (bus.imemAddr !== 16'h0008) begin errors++; $display("FAIL rw_addr0 got=%h exp=0008", bus.imemAddr); end
        redirect = 1'b1; redirectPC = 16'h0040;
        tick();
        redirect = 1'b0;
        checks++; if (bus.imemAddr !== 16'h0008) begin errors++; $display("FAIL rw_addr1 got=%h exp=0008", bus.imemAddr); end
        checks++; if (bus.imemReq !== 1'b1) begin errors++; $display("FAIL rw_req got=%b exp=1", bus.imemReq); end
        checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL rw_pc got=%h exp=0040", pc); end
        tick();
        checks++; if (bus.imemAddr !== 16'h0008) begin errors++; $display("FAIL rw_addr2 got=%h exp=0008", bus.imemAddr); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL rw_discard_valid got=%b exp=0", valid_IFID); end
        checks++; if (instr_IFID !== NOP) begin errors++; $display("FAIL rw_discard_instr got=%h exp=%h", instr_IFID, NOP); end
        checks++; if (bus.imemAddr !== 16'h0040) begin errors++; $display("FAIL rw_newaddr got=%h exp=0040", bus.imemAddr); end
        done = 1'b1;
        tick();
        checks++; if (instr_IFID !== 16'h6666) begin errors++; $display("FAIL rw_instr got=%h exp=6666", instr_IFID); end
        checks++; if (pc !== 16'h0042) begin errors++; $display("FAIL rw_pc2 got=%h exp=0042", pc); end
    endtask

    task automatic test_halt;
        mem[16'h000A] = 16'h0123;
        done = 1'b1; redirect = 1'b1; redirectPC = 16'h000A;
        tick();
        redirect = 1'b0;
        checks++; if (pc !== 16'h000A) begin errors++; $display("FAIL halt_pc0 got=%h exp=000a", pc); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (pc !== 16'h000A) begin errors++; $display("FAIL halt_pc got=%h exp=000a", pc); end
        checks++; if (instr_IFID !== 16'h0123) begin errors++; $display("FAIL halt_instr got=%h exp=0123", instr_IFID); end
        checks++; if (valid_IFID !== 1'b1) begin errors++; $display("FAIL halt_valid got=%b exp=1", valid_IFID); end
        done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL halt_req[%0d] got=%b exp=0", i, bus.imemReq); end
            tick();
            checks++; if (pc !== 16'h000A || halted !== 1'b1 || valid_IFID !== 1'b0) begin
                errors++; $display("FAIL halt_idle[%0d] pc=%h halted=%b valid=%b exp pc=000a halted=1 valid=0", i, pc, halted, valid_IFID);
            end
        end
        redirect = 1'b1; redirectPC = 16'h0010;
        tick();
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit got=%b exp=0", halted); end
        checks++; if (bus.imemAddr !== 16'h0010) begin errors++; $display("FAIL halt_addr got=%h exp=0010", bus.imemAddr); end
        checks++; if (bus.imemReq !== 1'b1) begin errors++; $display("FAIL halt_req_exit got=%b exp=1", bus.imemReq); end
    endtask

    task automatic test_priority_wrap;
        mem[16'hFFFE] = 16'h7ABC;
        done = 1'b1; redirect = 1'b1; branchStall = 1'b1; stall = 1'b1; redirectPC = 16'h1234;
        tick();
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL prio_pc got=%h exp=1234", pc); end
        checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL prio_valid got=%b exp=0", valid_IFID); end
        branchStall = 1'b0; stall = 1'b0; redirectPC = 16'hFFFE;
        tick();
        redirect = 1'b0;
        checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc0 got=%h exp=fffe", pc); end
        tick();
        checks++; if (pcPlus2_IFID !== 16'h0000) begin errors++; $display("FAIL wrap_pp2 got=%h exp=0000", pcPlus2_IFID); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
        checks++; if (instr_IFID !== 16'h7ABC) begin errors++; $display("FAIL wrap_instr got=%h exp=7abc", instr_IFID); end
    endtask

    task automatic test_reset_midread;
        done = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%b exp=0", bus.imemReq); end
        tick();
        checks++; if (pc !== 16'h0000 || valid_IFID !== 1'b0) begin errors++; $display("FAIL rstmid_state pc=%h valid=%b exp pc=0000 valid=0", pc, valid_IFID); end
        rst = 1'b0;
        tick();
        checks++; if (bus.imemAddr !== 16'h0000 || bus.imemReq !== 1'b1) begin errors++; $display("FAIL rstmid_refetch addr=%h req=%b exp addr=0000 req=1", bus.imemAddr, bus.imemReq); end
    endtask

    // Model view: a read is always in flight unless halted; its address is fixed at issue.
    task automatic test_random;
        logic [15:0] m_pc, m_instr, m_pp2, m_addr, exp_addr, data;
        logic        m_valid, m_halted, m_busy, m_squash, exp_req, r_rst, n_busy, n_squash;
        int          lat_left;
        lat_left = 0;
        for (int i = 0; i < 300; i++) mem[16'($urandom) & 16'hFFFE] = {5'b00000, 11'($urandom)};
        stall = 1'b0; branchStall = 1'b0; redirect = 1'b0; done = 1'b0; rst = 1'b1;
        tick();
        m_pc = 16'h0000; m_instr = NOP; m_pp2 = 16'h0000; m_addr = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_busy = 1'b0; m_squash = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r_rst       = ($urandom_range(0, 249) == 0);
            rst         = r_rst;
            stall       = ($urandom_range(0, 99) < 15);
            branchStall = ($urandom_range(0, 99) < 10);
            redirect    = ($urandom_range(0, 99) < 7);
            redirectPC  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : (16'($urandom_range(0, 64)) << 1) - 16'd6;
            exp_req  = !r_rst && !m_halted;
            exp_addr = m_busy ? m_addr : m_pc;
            if (exp_req) begin
                if (!m_busy) lat_left = $urandom_range(0, 3);
                else lat_left--;
                done = (lat_left == 0);
            end else begin
                done = ($urandom_range(0, 2) == 0);
            end
            #1;
            checks++; if (bus.imemReq !== exp_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", cyc, bus.imemReq, exp_req); end
            if (exp_req) begin
                checks++; if (bus.imemAddr !== exp_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", cyc, bus.imemAddr, exp_addr); end
            end
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", cyc, pc, m_pc); end
            checks++; if (instr_IFID !== m_instr) begin errors++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", cyc, instr_IFID, m_instr); end
            checks++; if (pcPlus2_IFID !== m_pp2) begin errors++; $display("FAIL rnd_pp2 c=%0d got=%h exp=%h", cyc, pcPlus2_IFID, m_pp2); end
            checks++; if (valid_IFID !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", cyc, valid_IFID, m_valid); end
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", cyc, halted, m_halted); end
            data = mem[exp_addr];
            if (r_rst) begin
                m_pc = 16'h0000; m_instr = NOP; m_pp2 = 16'h0000;
                m_valid = 1'b0; m_halted = 1'b0; m_busy = 1'b0; m_squash = 1'b0;
            end else if (m_halted) begin
                if (redirect) begin
                    m_pc = redirectPC; m_halted = 1'b0; m_instr = NOP; m_valid = 1'b0;
                end else if (branchStall || !stall) begin
                    m_instr = NOP; m_valid = 1'b0;
                end
            end else begin
                n_busy   = !done;
                n_squash = !done && (m_squash || redirect);
                if (redirect) begin
                    m_pc = redirectPC; m_instr = NOP; m_valid = 1'b0;
                end else if (branchStall) begin
                    m_instr = NOP; m_valid = 1'b0;
                end else if (stall) begin
                    m_valid = m_valid;
                end else if (done && !(m_busy && m_squash)) begin
                    m_instr = data; m_pp2 = exp_addr + 16'd2; m_valid = 1'b1;
                    if (data[15:11] == 5'b00000) begin
                        m_halted = 1'b1; m_pc = exp_addr;
                    end else begin
                        m_pc = exp_addr + 16'd2;
                    end
                end else begin
                    m_instr = NOP; m_valid = 1'b0;
                end
                m_busy = n_busy; m_squash = n_squash; m_addr = exp_addr;
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0; done = 1'b0; stall = 1'b0; branchStall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) w[11] = 1'b1;
            mem[i] = w;
        end
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_stall();
        test_redirect_wait();
        test_halt();
        test_priority_wrap();
        test_reset_midread();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
